// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues one word-aligned fetch at a time to
// instruction memory, holds the returned word for decode, and follows
// control-flow redirects from execute. Stale responses are squashed.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        drop_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        reqFire;
  logic        redirectOutstanding;

  // The request is only visible once reset is released, so no fetch can
  // start while reset is held even though the state already sits in REQ.
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign opcode     = inst_q[6:0];
  assign funct3     = inst_q[14:12];
  assign funct7_5   = inst_q[30];

  // A memory request is still in flight after this cycle if we were waiting
  // and nothing came back, or if a request is being accepted right now.
  assign redirectOutstanding = ((state_q == S_WAIT) && !imem_rsp_valid) ||
                               ((state_q == S_REQ) && imem_req_ready);

  // Fetch FSM: redirect outranks every other event; otherwise walk REQ->WAIT->HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC & PC_MASK;
      drop_q    <= 1'b0;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & PC_MASK;
      if (redirectOutstanding) begin
        state_q <= S_WAIT;
        drop_q  <= 1'b1;
      end else begin
        state_q <= S_REQ;
        drop_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (reqFire) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q    <= imem_rsp_data;
              inst_pc_q <= pc_q;
              state_q   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: walks reset, normal fetch, decode stall,
// redirects in WAIT/HOLD/REQ, pc wrap-around and reset during WAIT.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        instValid;
  logic        instReady;
  logic [31:0] instWord;
  logic [31:0] instPc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct75;
  logic        redirectValid;
  logic [31:0] redirectPc;

  int checkCount = 0;
  int passCount  = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imemReqValid),
    .imem_req_ready (imemReqReady),
    .imem_req_addr  (imemReqAddr),
    .imem_rsp_valid (imemRspValid),
    .imem_rsp_data  (imemRspData),
    .inst_valid     (instValid),
    .inst_ready     (instReady),
    .inst           (instWord),
    .inst_pc        (instPc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7_5       (funct75),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every DUT input for the coming cycle.
  task automatic applyStimulus(input logic reqReady, input logic rspValid,
                               input logic [31:0] rspData, input logic iReady,
                               input logic redirValid, input logic [31:0] redirPc);
    imemReqReady  = reqReady;
    imemRspValid  = rspValid;
    imemRspData   = rspData;
    instReady     = iReady;
    redirectValid = redirValid;
    redirectPc    = redirPc;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    checkOutput("rst_req_valid", 32'(imemReqValid), 32'd0);
    checkOutput("rst_inst_valid", 32'(instValid), 32'd0);
    checkOutput("rst_inst", instWord, 32'd0);
    checkOutput("rst_inst_pc", instPc, 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);

    rst = 1'b0;
    #1;
    checkOutput("boot_req_valid", 32'(imemReqValid), 32'd1);
    checkOutput("boot_req_addr", imemReqAddr, 32'h0000_0000);

    // Basic fetch: accept, respond next cycle, decode ready.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("wait_req_valid", 32'(imemReqValid), 32'd0);
    checkOutput("wait_inst_valid", 32'(instValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0051_0113, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("f0_inst_valid", 32'(instValid), 32'd1);
    checkOutput("f0_inst", instWord, 32'h0051_0113);
    checkOutput("f0_inst_pc", instPc, 32'h0000_0000);
    checkOutput("f0_opcode", 32'(opcode), 32'h13);
    checkOutput("f0_funct3", 32'(funct3), 32'd0);
    checkOutput("f0_funct7_5", 32'(funct75), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("f0_next_valid", 32'(imemReqValid), 32'd1);
    checkOutput("f0_next_addr", imemReqAddr, 32'h0000_0004);
    checkOutput("f0_inst_drop", 32'(instValid), 32'd0);

    // Decode stall for five cycles.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h4020_8033, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("stall_opcode", 32'(opcode), 32'h33);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d_inst", i), instWord, 32'h4020_8033);
      checkOutput($sformatf("stall%0d_f75", i), 32'(funct75), 32'd1);
      checkOutput($sformatf("stall%0d_pc", i), instPc, 32'h0000_0004);
      checkOutput($sformatf("stall%0d_valid", i), 32'(instValid), 32'd1);
      checkOutput($sformatf("stall%0d_noreq", i), 32'(imemReqValid), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("stall_next_addr", imemReqAddr, 32'h0000_0008);

    // Redirect while waiting with no response: stale response squashed.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0102);
    tick();
    checkOutput("rw_req_valid", 32'(imemReqValid), 32'd0);
    checkOutput("rw_inst_valid", 32'(instValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("rw_stale_valid", 32'(instValid), 32'd0);
    checkOutput("rw_req_valid2", 32'(imemReqValid), 32'd1);
    checkOutput("rw_req_addr", imemReqAddr, 32'h0000_0100);

    // Redirect in HOLD while decode is ready: target wins over pc+4.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("rh_inst_pc", instPc, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("rh_inst_valid", 32'(instValid), 32'd0);
    checkOutput("rh_req_valid", 32'(imemReqValid), 32'd1);
    checkOutput("rh_req_addr", imemReqAddr, 32'h0000_0200);

    // Redirect in REQ while memory accepts: that request becomes stale.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("rr_req_valid", 32'(imemReqValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("rr_stale_valid", 32'(instValid), 32'd0);
    checkOutput("rr_req_addr", imemReqAddr, 32'hFFFF_FFFC);

    // Fetch at the top of the address space and wrap to zero.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0093, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_inst_pc", instPc, 32'hFFFF_FFFC);
    checkOutput("wrap_inst", instWord, 32'h0000_0093);
    tick();
    checkOutput("wrap_req_addr", imemReqAddr, 32'h0000_0000);

    // Reset during WAIT, late response ignored.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rw_rst_req_valid", 32'(imemReqValid), 32'd0);
    checkOutput("rw_rst_inst_valid", 32'(instValid), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rw_boot_addr", imemReqAddr, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("late_inst_valid", 32'(instValid), 32'd0);
    checkOutput("late_req_valid", 32'(imemReqValid), 32'd1);
    checkOutput("late_req_addr", imemReqAddr, 32'h0000_0000);
    tick();
    checkOutput("late_inst_valid2", 32'(instValid), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
